// File: rtl/target_tb_if.sv
// ----------------------------------------------------------------------------
// target_tb_if
//   Core-side target interface bundle between the PCI core and the
//   behavioural target application.
//
//   master : core side. It drives address/data, strobes and byte enables,
//            and receives read data plus the ready/terminate/abort handshake.
//   slave  : target application side (target_tb).
//
//   adio_out    core address/write-data bus
//   adio_in     read data back to the core (high-Z outside a read)
//   addr_vld    address-phase strobe
//   base_hit    BAR decode vector
//   s_wrdn      direction, 1 = write
//   s_data      high across the data phases
//   s_data_vld  a data phase completes this cycle
//   s_src_en    advance the read source
//   s_cbe       active-low byte enables
//   s_ready     target ready
//   s_term      terminate request (retry when !s_ready, disconnect when s_ready)
//   s_abort     target abort
// ----------------------------------------------------------------------------
interface target_tb_if;
    logic [31:0] adio_out;
    logic [31:0] adio_in;
    logic        addr_vld;
    logic [7:0]  base_hit;
    logic        s_wrdn;
    logic        s_data;
    logic        s_data_vld;
    logic        s_src_en;
    logic [3:0]  s_cbe;
    logic        s_ready;
    logic        s_term;
    logic        s_abort;

    modport master (
        output adio_out, addr_vld, base_hit, s_wrdn, s_data, s_data_vld,
               s_src_en, s_cbe,
        input  adio_in, s_ready, s_term, s_abort
    );

    modport slave (
        input  adio_out, addr_vld, base_hit, s_wrdn, s_data, s_data_vld,
               s_src_en, s_cbe,
        output adio_in, s_ready, s_term, s_abort
    );
endinterface

// File: rtl/target_tb.sv
// ----------------------------------------------------------------------------
// target_tb
//   Target-side user application for the PCI core. It claims accesses that
//   hit BAR0 and backs them with a DEPTH x 32-bit memory. It serves single and
//   burst reads/writes with byte enables. It can also issue a one-shot retry,
//   a disconnect after term_after data phases, or a target abort.
//
//   CLK         core clock, rising edge
//   reset_n     asynchronous active-low reset
//   bus         target interface (slave modport)
//   cfg_retry   retry the next hit once (sampled at the hit)
//   cfg_abort   target-abort the next hit (sampled at the hit)
//   term_after  disconnect after this many data phases, 0 = never
//   wr_count    accepted write phases (wraps)
//   rd_count    accepted read phases (wraps)
// ----------------------------------------------------------------------------
module target_tb #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         CLK,
    input  logic         reset_n,
    target_tb_if.slave   bus,
    input  logic         cfg_retry,
    input  logic         cfg_abort,
    input  logic [3:0]   term_after,
    output logic [15:0]  wr_count,
    output logic [15:0]  rd_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RETRY,
        S_ABORT
    } state_t;

    state_t        c_state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_next;
    logic [AW-1:0] hit_addr;
    logic [15:0]   cnt;
    logic [31:0]   q;
    logic          retried;
    logic          s_dataq;
    logic          s_data_fell;
    logic          hit;
    logic [3:0]    term_lim;
    logic          unused_ok;

    assign s_data_fell = ~bus.s_data & s_dataq;
    assign hit_addr    = bus.adio_out[AW+1:2];
    assign ptr_next    = ptr + 1'b1;   // wraps modulo DEPTH through the AW-bit width
    // A hit is also accepted in the cycle the previous transaction ends, so
    // back-to-back transactions need no idle cycle.
    assign hit         = bus.addr_vld & bus.base_hit[0] &
                         ((c_state == S_IDLE) | s_data_fell);
    assign term_lim    = term_after - 4'd1;

    // Only BAR0 and the word-address bits are decoded.
    assign unused_ok = ^{bus.base_hit[7:1], bus.adio_out[31:AW+2], bus.adio_out[1:0]};

    // Control, pointer, prefetch and counters.
    // NOTE: sequential state uses non-blocking assignments only; a later
    // assignment in the same block (the hit) overrides the data-phase update.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            c_state  <= S_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            q        <= '0;
            retried  <= 1'b0;
            s_dataq  <= 1'b0;
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            s_dataq <= bus.s_data;

            if (c_state == S_WRITE && bus.s_data_vld) begin
                ptr      <= ptr_next;
                cnt      <= cnt + 16'd1;
                wr_count <= wr_count + 16'd1;
            end

            if (c_state == S_READ) begin
                if (bus.s_src_en) begin
                    ptr <= ptr_next;
                    q   <= mem[ptr_next];
                end
                if (bus.s_data_vld) begin
                    cnt      <= cnt + 16'd1;
                    rd_count <= rd_count + 16'd1;
                end
            end

            if (hit) begin
                ptr <= hit_addr;
                cnt <= '0;
                q   <= mem[hit_addr];
                if (cfg_abort) begin
                    c_state <= S_ABORT;
                end else if (cfg_retry && !retried) begin
                    c_state <= S_RETRY;
                    retried <= 1'b1;
                end else begin
                    c_state <= bus.s_wrdn ? S_WRITE : S_READ;
                    retried <= 1'b0;
                end
            end else if (s_data_fell) begin
                c_state <= S_IDLE;
            end
        end
    end

    // Backing store with per-byte write enables.
    // NOTE: the memory has no reset; its contents survive reset_n by design.
    always_ff @(posedge CLK) begin
        if (c_state == S_WRITE && bus.s_data_vld) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.s_cbe[i]) begin
                    mem[ptr][8*i +: 8] <= bus.adio_out[8*i +: 8];
                end
            end
        end
    end

    // Handshake outputs are a pure decode of the registered state and count.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        bus.s_ready = 1'b0;
        bus.s_term  = 1'b0;
        bus.s_abort = 1'b0;
        unique case (c_state)
            S_READ, S_WRITE: begin
                bus.s_ready = 1'b1;
                bus.s_term  = (term_after != 4'd0) && (cnt >= {12'd0, term_lim});
            end
            S_RETRY: begin
                bus.s_term = 1'b1;
            end
            S_ABORT: begin
                bus.s_term  = 1'b1;
                bus.s_abort = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.adio_in = (c_state == S_READ) ? q : 32'hz;

endmodule
